// File: rtl/wstage_elastic_buf.sv
// Elastic buffer for inter-stage pipeline payloads: DEPTH-entry circular queue
// with valid/ready on both sides, synchronous flush and a sticky protocol monitor.
module wstage_elastic_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  count,
  output logic              overflow_err
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              err_q, err_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] sdata_q;
  logic              push, pop;

  assign push = s_valid & s_ready_q;
  assign pop  = m_valid_q & m_ready;

  // Next-state: flush wins over any concurrent push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
    s_ready_d = (count_d < CNT_FULL);
    m_valid_d = (count_d != '0);
    // A stalled beat whose payload changes before acceptance is a protocol error.
    stall_d   = s_valid & ~s_ready_q & ~flush;
    err_d     = err_q | (stall_q & s_valid & ~flush & (s_data != sdata_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
      sdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
      stall_q   <= stall_d;
      sdata_q   <= s_data;
    end
  end

  // Payload storage; a push dropped by flush never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = mem_q[rd_ptr_q];
  assign count        = count_q;
  assign overflow_err = err_q;

endmodule
